// File: rtl/posit_shift_sched_if.sv
// Request/result bundle for posit_shift_sched: two valid/ready requesters and one result port.
// Grant counters exist only when POSIT_SHIFT_GRANT_CNT_EN is defined.
interface posit_shift_sched_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  typedef logic [CNT_W-1:0] gcnt_t;

  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] a_data;
  logic [1:0]    a_mode;
  logic [19:0]   a_cnt;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] b_data;
  logic [1:0]    b_mode;
  logic [19:0]   b_cnt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic [1:0]    out_mode;
  logic          out_err;
`ifdef POSIT_SHIFT_GRANT_CNT_EN
  gcnt_t         a_gcnt;
  gcnt_t         b_gcnt;

  modport slave (
    input  a_valid, a_data, a_mode, a_cnt, b_valid, b_data, b_mode, b_cnt, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src, out_mode, out_err, a_gcnt, b_gcnt
  );
  modport master (
    output a_valid, a_data, a_mode, a_cnt, b_valid, b_data, b_mode, b_cnt, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src, out_mode, out_err, a_gcnt, b_gcnt
  );
`else
  modport slave (
    input  a_valid, a_data, a_mode, a_cnt, b_valid, b_data, b_mode, b_cnt, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src, out_mode, out_err
  );
  modport master (
    output a_valid, a_data, a_mode, a_cnt, b_valid, b_data, b_mode, b_cnt, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src, out_mode, out_err
  );
`endif
endinterface

// File: rtl/posit_shift_sched.sv
// Round-robin scheduler sharing one packed-lane posit left shifter between operand paths A and B.
// Optional per-requester grant counters are enabled by defining POSIT_SHIFT_GRANT_CNT_EN.
module posit_shift_sched #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  posit_shift_sched_if.slave bus
);
  if (DW != 32 || CNT_W < 1) begin : g_param_check
    $error("posit_shift_sched: DW must be 32 and CNT_W must be positive");
  end

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [1:0]    s1_mode_q, s1_mode_d;
  logic [19:0]   s1_cnt_q, s1_cnt_d;
  logic          s1_src_q, s1_src_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_src_q, out_src_d;
  logic [1:0]    out_mode_q, out_mode_d;
  logic          out_err_q, out_err_d;
  logic          pri_q, pri_d;

  logic          s2_load, s1_open, grant_a, grant_b, accept_a, accept_b;
  logic [DW-1:0] shift_res;
  logic          shift_err;

  // Applied shift is count+1 so the regime terminator bit is dropped too.
  always_comb begin
    shift_res = '0;
    case (s1_mode_q)
      2'b00: begin
        for (int i = 0; i < 4; i++) begin
          shift_res[8*i +: 8] = s1_data_q[8*i +: 8] << ({2'b00, s1_cnt_q[5*i +: 4]} + 6'd1);
        end
      end
      2'b01: begin
        shift_res[15:0]  = s1_data_q[15:0]  << ({1'b0, s1_cnt_q[4:0]} + 6'd1);
        shift_res[31:16] = s1_data_q[31:16] << ({1'b0, s1_cnt_q[9:5]} + 6'd1);
      end
      default: shift_res = s1_data_q << ({1'b0, s1_cnt_q[4:0]} + 6'd1);
    endcase
    shift_err = (s1_mode_q == 2'b11) ||
                ((s1_mode_q == 2'b00) &&
                 (s1_cnt_q[4] || s1_cnt_q[9] || s1_cnt_q[14] || s1_cnt_q[19]));
  end

  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || bus.out_ready);
    s1_open  = !rst && (!s1_valid_q || s2_load);
    grant_b  = bus.b_valid && (!bus.a_valid || pri_q);
    grant_a  = bus.a_valid && !grant_b;
    accept_a = grant_a && s1_open;
    accept_b = grant_b && s1_open;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_cnt_d   = s1_cnt_q;
    s1_src_d   = s1_src_q;
    if (accept_a || accept_b) begin
      s1_valid_d = 1'b1;
      s1_data_d  = accept_b ? bus.b_data : bus.a_data;
      s1_mode_d  = accept_b ? bus.b_mode : bus.a_mode;
      s1_cnt_d   = accept_b ? bus.b_cnt  : bus.a_cnt;
      s1_src_d   = accept_b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_res;
      out_src_d   = s1_src_q;
      out_mode_d  = s1_mode_q;
      out_err_d   = shift_err;
    end

    pri_d = accept_a || (pri_q && !accept_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= '0;
      s1_cnt_q    <= '0;
      s1_src_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_mode_q  <= '0;
      out_err_q   <= 1'b0;
      pri_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_src_q    <= s1_src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
      pri_q       <= pri_d;
    end
  end

  assign bus.a_ready   = accept_a;
  assign bus.b_ready   = accept_b;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_err   = out_err_q;

`ifdef POSIT_SHIFT_GRANT_CNT_EN
  logic [CNT_W-1:0] a_gcnt_q, a_gcnt_d, b_gcnt_q, b_gcnt_d;

  always_comb begin
    a_gcnt_d = a_gcnt_q;
    b_gcnt_d = b_gcnt_q;
    if (accept_a && (a_gcnt_q != '1)) a_gcnt_d = a_gcnt_q + 1'b1;
    if (accept_b && (b_gcnt_q != '1)) b_gcnt_d = b_gcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_gcnt_q <= '0;
      b_gcnt_q <= '0;
    end else begin
      a_gcnt_q <= a_gcnt_d;
      b_gcnt_q <= b_gcnt_d;
    end
  end

  assign bus.a_gcnt = a_gcnt_q;
  assign bus.b_gcnt = b_gcnt_q;
`endif
endmodule

// File: tb/tb_posit_shift_sched.sv
// Directed bench for posit_shift_sched: lane shifts, error flag, arbitration, stalls and reset.
module tb_posit_shift_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  posit_shift_sched_if #(.DW(32), .CNT_W(16)) bus ();
  posit_shift_sched #(.DW(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one word on a single requester, require it to be taken this cycle.
  task automatic push(input bit side, input logic [31:0] d, input logic [1:0] m, input logic [19:0] c);
    if (side) begin
      bus.b_valid = 1'b1; bus.b_data = d; bus.b_mode = m; bus.b_cnt = c;
    end else begin
      bus.a_valid = 1'b1; bus.a_data = d; bus.a_mode = m; bus.a_cnt = c;
    end
    @(negedge clk);
    chk("push_ready", {31'b0, side ? bus.b_ready : bus.a_ready}, 32'd1);
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic s,
                            input logic [1:0] m, input logic e);
    @(negedge clk);
    chk($sformatf("%s_valid", tag), {31'b0, bus.out_valid}, 32'd1);
    chk($sformatf("%s_data", tag), bus.out_data, d);
    chk($sformatf("%s_src", tag), {31'b0, bus.out_src}, {31'b0, s});
    chk($sformatf("%s_mode", tag), {30'b0, bus.out_mode}, {30'b0, m});
    chk($sformatf("%s_err", tag), {31'b0, bus.out_err}, {31'b0, e});
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_data = '0; bus.a_mode = '0; bus.a_cnt = '0;
    bus.b_valid = 1'b0; bus.b_data = '0; bus.b_mode = '0; bus.b_cnt = '0;
    bus.out_ready = 1'b1;

    // Reset state, with a requester already waiting
    tick();
    bus.a_valid = 1'b1; bus.a_data = 32'hFF; bus.a_mode = 2'b10; bus.a_cnt = 20'd3;
    @(negedge clk);
    chk("rst_a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("rst_b_ready", {31'b0, bus.b_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_src", {31'b0, bus.out_src}, 32'd0);
    chk("rst_out_mode", {30'b0, bus.out_mode}, 32'd0);
    chk("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    tick();
    rst = 1'b0;
    bus.a_valid = 1'b0;

    // Single-word shifts, one per mode
    push(1'b0, 32'h000000FF, 2'b10, 20'd3);
    @(negedge clk);
    chk("lat_not_yet", {31'b0, bus.out_valid}, 32'd0);
    tick();
    expect_out("m10_a", 32'h00000FF0, 1'b0, 2'b10, 1'b0);

    push(1'b1, 32'h81818181, 2'b00, 20'h18820); tick();
    expect_out("m00_b", 32'h10080402, 1'b1, 2'b00, 1'b0);

    push(1'b0, 32'h80018001, 2'b01, 20'h001C0); tick();
    expect_out("m01", 32'h80000002, 1'b0, 2'b01, 1'b0);

    push(1'b0, 32'h81818181, 2'b00, 20'h04000); tick();
    expect_out("m00_c4", 32'h02020202, 1'b0, 2'b00, 1'b1);

    push(1'b1, 32'hFFFFFFFF, 2'b00, 20'h019E7); tick();
    expect_out("m00_wide", 32'hFE800000, 1'b1, 2'b00, 1'b0);

    push(1'b0, 32'hFFFFFFFF, 2'b10, 20'd31); tick();
    expect_out("m10_wide", 32'h00000000, 1'b0, 2'b10, 1'b0);

    push(1'b1, 32'hFFFFFFFF, 2'b01, 20'h0002F); tick();
    expect_out("m01_wide", 32'hFFFC0000, 1'b1, 2'b01, 1'b0);

    push(1'b0, 32'h000000FF, 2'b11, 20'd4); tick();
    expect_out("m11", 32'h00001FE0, 1'b0, 2'b11, 1'b1);

    // Round-robin with both requesters always valid
    rst = 1'b1; tick(); rst = 1'b0;
    bus.a_data = 32'h1;   bus.a_mode = 2'b10; bus.a_cnt = '0;
    bus.b_data = 32'h100; bus.b_mode = 2'b10; bus.b_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      bus.a_valid = (i < 6);
      bus.b_valid = (i < 6);
      @(negedge clk);
      if (i < 6) begin
        chk("alt_a_ready", {31'b0, bus.a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
        chk("alt_b_ready", {31'b0, bus.b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (i >= 2) begin
        chk("alt_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("alt_out_src", {31'b0, bus.out_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
        chk("alt_out_data", bus.out_data, (i % 2 == 0) ? 32'h2 : 32'h200);
      end else begin
        chk("alt_out_empty", {31'b0, bus.out_valid}, 32'd0);
      end
      tick();
    end
`ifdef POSIT_SHIFT_GRANT_CNT_EN
    chk("gcnt_a_alt", {16'b0, bus.a_gcnt}, 32'd3);
    chk("gcnt_b_alt", {16'b0, bus.b_gcnt}, 32'd3);
`endif

    // Back-pressure with both stages full
    bus.out_ready = 1'b0;
    push(1'b0, 32'h00000003, 2'b10, 20'd1);
    push(1'b1, 32'h00F00000, 2'b01, 20'h00060);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_a_ready", {31'b0, bus.a_ready}, 32'd0);
      chk("stall_b_ready", {31'b0, bus.b_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_out_data", bus.out_data, 32'h0000000C);
      tick();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.out_ready = 1'b1;
    expect_out("drain_1", 32'h0000000C, 1'b0, 2'b10, 1'b0);
    expect_out("drain_2", 32'h0F000000, 1'b1, 2'b01, 1'b0);
    @(negedge clk);
    chk("drain_empty", {31'b0, bus.out_valid}, 32'd0);
    tick();

    // Reset while both stages hold data and pri points at B
    bus.out_ready = 1'b0;
    push(1'b0, 32'h000000FF, 2'b10, 20'd0);
    push(1'b0, 32'h000000FF, 2'b10, 20'd1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    @(negedge clk);
    chk("midrst_a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("midrst_b_ready", {31'b0, bus.b_ready}, 32'd0);
    tick();
    rst = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
`ifdef POSIT_SHIFT_GRANT_CNT_EN
    chk("midrst_gcnt_a", {16'b0, bus.a_gcnt}, 32'd0);
    chk("midrst_gcnt_b", {16'b0, bus.b_gcnt}, 32'd0);
`endif
    tick();
    @(negedge clk);
    chk("midrst_no_stale", {31'b0, bus.out_valid}, 32'd0);
    tick();
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    @(negedge clk);
    chk("midrst_pri_a", {31'b0, bus.a_ready}, 32'd1);
    chk("midrst_pri_b", {31'b0, bus.b_ready}, 32'd0);
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
